// File: rtl/cmlk_timing_pkg.sv
// Shared timing definitions for the CMOS/laser pulse sequencer: FSM states,
// default widths and the window-decode helper.
package cmlk_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned PERIOD_MIN_DEF = 4;
  localparam int unsigned CNT_W_MAX      = 64;

  // The stop point is one bit wider than the operands so delay+width never wraps.
  function automatic logic win_hit(input logic [CNT_W_MAX-1:0] cnt,
                                   input logic [CNT_W_MAX-1:0] delay,
                                   input logic [CNT_W_MAX-1:0] width);
    logic [CNT_W_MAX:0] stop;
    stop = {1'b0, delay} + {1'b0, width};
    return (cnt >= delay) && ({1'b0, cnt} < stop);
  endfunction

endpackage

// File: rtl/cmlk_window_decode.sv
// Registered window decode: hit is high one clock after cnt lies in
// [delay, delay+width) while active.
module cmlk_window_decode
  import cmlk_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
    end else begin
      hit <= active && win_hit(CNT_W_MAX'(cnt), CNT_W_MAX'(delay), CNT_W_MAX'(width));
    end
  end

endmodule

// File: rtl/cmlk_pulse_sequencer.sv
// Laser trigger / dual frame-gate sequencer with period-boundary shadow loads.
// Optional burst limit enabled by defining CMLK_BURST_LIMIT_EN.
module cmlk_pulse_sequencer
  import cmlk_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             param_update,
  input  logic [CNT_W-1:0] laser_period_i,
  input  logic [CNT_W-1:0] laser_width_i,
  input  logic [CNT_W-1:0] gate_delay_a_i,
  input  logic [CNT_W-1:0] gate_width_a_i,
  input  logic [CNT_W-1:0] gate_delay_b_i,
  input  logic [CNT_W-1:0] gate_width_b_i,
  input  logic [7:0]       tim_cycles_m_i,
  output logic             laser_trig_o,
  output logic             gate_a_o,
  output logic             gate_b_o,
  output logic             period_start_o,
  output logic             busy_o,
`ifdef CMLK_BURST_LIMIT_EN
  output logic             burst_done_o,
`endif
  output logic [15:0]      period_cnt_o
);

  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PERIOD_MIN);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [15:0]      pcnt_next;
  logic             load, at_top, active;
  logic [CNT_W-1:0] zero_delay;

  logic [CNT_W-1:0] period_pend, lwidth_pend, da_pend, wa_pend, db_pend, wb_pend;
  logic             pend_valid;
  logic [CNT_W-1:0] period_s, lwidth_s, da_s, wa_s, db_s, wb_s;

`ifdef CMLK_BURST_LIMIT_EN
  logic [7:0] m_pend, m_s;
  logic       armed, burst_end;
`else
  logic       unused_m;
  assign unused_m = ^tim_cycles_m_i;
`endif

  assign at_top     = (cnt == period_s);
  assign active     = (state != IDLE);
  assign zero_delay = '0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pcnt_next  = period_cnt_o;
    load       = 1'b0;
`ifdef CMLK_BURST_LIMIT_EN
    burst_end  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
`ifdef CMLK_BURST_LIMIT_EN
        if (enable && armed) begin
`else
        if (enable) begin
`endif
          state_next = RUN;
          load       = pend_valid;
          pcnt_next  = '0;
        end
      end
      default: begin
        cnt_next = at_top ? '0 : cnt + CNT_W'(1);
        if (at_top) begin
          pcnt_next = period_cnt_o + 16'd1;
          load      = pend_valid;
        end
        if (state == RUN) begin
          if (!enable) state_next = DRAIN;
`ifdef CMLK_BURST_LIMIT_EN
          // Limit check overrides a simultaneous RUN->DRAIN: the burst ends here.
          if (at_top && (m_s != 8'd0) && (pcnt_next == {8'd0, m_s})) begin
            state_next = IDLE;
            burst_end  = 1'b1;
          end
`endif
        end else if (enable) begin
          state_next = RUN;
        end else if (at_top) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      period_cnt_o   <= '0;
      period_start_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      period_cnt_o   <= pcnt_next;
      period_start_o <= active && (cnt == '0);
      busy_o         <= active;
    end
  end

  // A strobe coinciding with a load refills pending and keeps it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_pend <= '0; lwidth_pend <= '0; da_pend <= '0;
      wa_pend     <= '0; db_pend     <= '0; wb_pend <= '0;
      pend_valid  <= 1'b0;
      period_s    <= '0; lwidth_s    <= '0; da_s    <= '0;
      wa_s        <= '0; db_s        <= '0; wb_s    <= '0;
    end else begin
      if (load) begin
        period_s   <= (period_pend < P_MIN) ? P_MIN : period_pend;
        lwidth_s   <= lwidth_pend;
        da_s       <= da_pend;
        wa_s       <= wa_pend;
        db_s       <= db_pend;
        wb_s       <= wb_pend;
        pend_valid <= 1'b0;
      end
      if (param_update) begin
        period_pend <= laser_period_i;
        lwidth_pend <= laser_width_i;
        da_pend     <= gate_delay_a_i;
        wa_pend     <= gate_width_a_i;
        db_pend     <= gate_delay_b_i;
        wb_pend     <= gate_width_b_i;
        pend_valid  <= 1'b1;
      end
    end
  end

`ifdef CMLK_BURST_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend       <= '0;
      m_s          <= '0;
      armed        <= 1'b1;
      burst_done_o <= 1'b0;
    end else begin
      if (load)         m_s    <= m_pend;
      if (param_update) m_pend <= tim_cycles_m_i;
      if (burst_end)    armed  <= 1'b0;
      else if (!enable) armed  <= 1'b1;
      burst_done_o <= burst_end;
    end
  end
`endif

  cmlk_window_decode #(.CNT_W(CNT_W)) u_laser (
    .clk(clk), .rst_n(rst_n), .active(active), .cnt(cnt),
    .delay(zero_delay), .width(lwidth_s), .hit(laser_trig_o)
  );

  cmlk_window_decode #(.CNT_W(CNT_W)) u_gate_a (
    .clk(clk), .rst_n(rst_n), .active(active), .cnt(cnt),
    .delay(da_s), .width(wa_s), .hit(gate_a_o)
  );

  cmlk_window_decode #(.CNT_W(CNT_W)) u_gate_b (
    .clk(clk), .rst_n(rst_n), .active(active), .cnt(cnt),
    .delay(db_s), .width(wb_s), .hit(gate_b_o)
  );

endmodule

// File: tb/tb_cmlk_pulse_sequencer.sv
// Scoreboard bench for cmlk_pulse_sequencer: a cycle model pushes expected
// outputs as each cycle's stimulus is applied; they are popped after the edge.
module tb_cmlk_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, enable, param_update;
  logic [31:0] laser_period_i, laser_width_i;
  logic [31:0] gate_delay_a_i, gate_width_a_i, gate_delay_b_i, gate_width_b_i;
  logic [7:0]  tim_cycles_m_i;
  logic        laser_trig_o, gate_a_o, gate_b_o, period_start_o, busy_o;
  logic [15:0] period_cnt_o;
`ifdef CMLK_BURST_LIMIT_EN
  logic        burst_done_o;
`endif

  always #5 clk = ~clk;

  cmlk_pulse_sequencer #(.CNT_W(32), .PERIOD_MIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .param_update(param_update),
    .laser_period_i(laser_period_i), .laser_width_i(laser_width_i),
    .gate_delay_a_i(gate_delay_a_i), .gate_width_a_i(gate_width_a_i),
    .gate_delay_b_i(gate_delay_b_i), .gate_width_b_i(gate_width_b_i),
    .tim_cycles_m_i(tim_cycles_m_i),
    .laser_trig_o(laser_trig_o), .gate_a_o(gate_a_o), .gate_b_o(gate_b_o),
    .period_start_o(period_start_o), .busy_o(busy_o),
`ifdef CMLK_BURST_LIMIT_EN
    .burst_done_o(burst_done_o),
`endif
    .period_cnt_o(period_cnt_o)
  );

  typedef struct {
    logic        laser, ga, gb, ps, busy;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0, n_fail = 0;

  // Reference model state (0 idle, 1 run, 2 drain).
  int     m_state;
  longint m_cnt, m_p, m_wl, m_da, m_wa, m_db, m_wb;
  longint q_p, q_wl, q_da, q_wa, q_db, q_wb;
  bit     q_v;
  int     m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pc = 0;
    m_p = 0; m_wl = 0; m_da = 0; m_wa = 0; m_db = 0; m_wb = 0;
    q_p = 0; q_wl = 0; q_da = 0; q_wa = 0; q_db = 0; q_wb = 0; q_v = 0;
  endtask

  task automatic step();
    exp_t e;
    bit   bnd, ld;
    e.busy  = (m_state != 0);
    e.laser = e.busy && (m_cnt < m_wl);
    e.ga    = e.busy && (m_cnt >= m_da) && ((m_cnt - m_da) < m_wa);
    e.gb    = e.busy && (m_cnt >= m_db) && ((m_cnt - m_db) < m_wb);
    e.ps    = e.busy && (m_cnt == 0);
    bnd = (m_cnt == m_p);
    ld  = 0;
    if (m_state == 0) begin
      if (enable) begin
        ld = q_v; m_state = 1; m_cnt = 0; m_pc = 0;
      end
    end else begin
      ld = bnd && q_v;
      if (bnd) m_pc = (m_pc + 1) % 65536;
      m_cnt = bnd ? 0 : m_cnt + 1;
      if (m_state == 1) begin
        if (!enable) m_state = 2;
      end else if (enable) m_state = 1;
      else if (bnd) m_state = 0;
    end
    if (ld) begin
      m_p = (q_p < 4) ? 4 : q_p;
      m_wl = q_wl; m_da = q_da; m_wa = q_wa; m_db = q_db; m_wb = q_wb;
      q_v = 0;
    end
    if (param_update) begin
      q_p = laser_period_i; q_wl = laser_width_i;
      q_da = gate_delay_a_i; q_wa = gate_width_a_i;
      q_db = gate_delay_b_i; q_wb = gate_width_b_i; q_v = 1;
    end
    e.pc = m_pc[15:0];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    param_update = 1'b0;
    e = sb.pop_front();
    check("laser_trig", {31'd0, laser_trig_o},   {31'd0, e.laser});
    check("gate_a",     {31'd0, gate_a_o},       {31'd0, e.ga});
    check("gate_b",     {31'd0, gate_b_o},       {31'd0, e.gb});
    check("period_start", {31'd0, period_start_o}, {31'd0, e.ps});
    check("busy",       {31'd0, busy_o},         {31'd0, e.busy});
    check("period_cnt", {16'd0, period_cnt_o},   {16'd0, e.pc});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_cnt(input longint c);
    int k = 0;
    while (m_cnt != c && k < 100) begin
      step();
      k++;
    end
  endtask

  task automatic set_params(input longint p, wl, da, wa, db, wb);
    laser_period_i = 32'(p);  laser_width_i  = 32'(wl);
    gate_delay_a_i = 32'(da); gate_width_a_i = 32'(wa);
    gate_delay_b_i = 32'(db); gate_width_b_i = 32'(wb);
    param_update   = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_laser"}, {31'd0, laser_trig_o}, 32'd0);
    check({tag, "_gate_a"}, {31'd0, gate_a_o}, 32'd0);
    check({tag, "_gate_b"}, {31'd0, gate_b_o}, 32'd0);
    check({tag, "_pstart"}, {31'd0, period_start_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_pcnt"}, {16'd0, period_cnt_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; param_update = 1'b0; tim_cycles_m_i = 8'd0;
    laser_period_i = '0; laser_width_i = '0;
    gate_delay_a_i = '0; gate_width_a_i = '0; gate_delay_b_i = '0; gate_width_b_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Start-up and gate placement, gate B truncated at P.
    set_params(9, 3, 2, 4, 8, 5);
    step();
    enable = 1'b1;
    run(32);

    // Mid-period update to P=19: current period finishes unchanged.
    run_until_cnt(4);
    set_params(19, 3, 2, 4, 8, 5);
    run(50);

    // Gate B delay beyond P never asserts; then stop with enable low at cnt 3.
    set_params(9, 3, 2, 4, 12, 5);
    run_until_cnt(0);
    run(12);
    run_until_cnt(3);
    enable = 1'b0;
    run(15);

    // Restart, drop at cnt 3 and re-raise at cnt 6: no gap.
    enable = 1'b1;
    run(12);
    run_until_cnt(3);
    enable = 1'b0;
    run_until_cnt(6);
    enable = 1'b1;
    run(20);

    // Period clamp, then laser wider than the period and zero gate A width.
    set_params(1, 2, 0, 2, 1, 3);
    run(20);
    set_params(9, 50, 2, 0, 3, 2);
    run(30);
    enable = 1'b0;
    run(15);

    // Async reset mid-period with outputs high.
    set_params(9, 3, 2, 4, 8, 5);
    enable = 1'b1;
    run(15);
    run_until_cnt(5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    sb.delete();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Restart without pending: zero shadow; then a strobe loads on the next boundary.
    enable = 1'b1;
    run(6);
    set_params(9, 3, 2, 4, 8, 5);
    run(25);
    enable = 1'b0;
    run(12);

    // Pending strobed while idle is loaded on the IDLE->RUN transition.
    set_params(6, 2, 1, 1, 0, 0);
    step();
    enable = 1'b1;
    run(20);
    enable = 1'b0;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
